ks_adder_arbiter: RTL and testbench
===================================

// Module: ks_adder_arbiter
// PURPOSE
//   Shares one 16-bit kogg_stone adder (a + b, 16-bit sum, no carry out) between NUM_REQ requesters.
//   Each requester offers an operand pair on a valid/ready handshake. A round-robin arbiter grants one
//   requester per cycle. The operands feed a 2-stage pipeline (operand register -> adder -> result
//   register). The sum returns on a single response channel tagged with the requester id.
// PARAMETERS
//   NUM_REQ  4  number of requesters, 2..8
//   ID_W     2  response id width, must be >= clog2(NUM_REQ)
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous, active-high reset
//   req_valid  in   NUM_REQ     per-requester operand valid
//   req_a      in   16*NUM_REQ  operand A; requester i uses bits [16*i+15:16*i]
//   req_b      in   16*NUM_REQ  operand B; same packing as req_a
//   req_ready  out  NUM_REQ     per-requester accept; one-hot or zero
//   rsp_valid  out  1           result valid
//   rsp_sum    out  16          (a + b) mod 2^16
//   rsp_id     out  ID_W        index of the requester that owns rsp_sum
//   rsp_ready  in   1           downstream accept
//   rsp_carry  out  1           carry out of the add; present only with KS_ARB_CARRY_EN
// BEHAVIOUR
//   - Reset (async assert, sync release):
//       s1_valid = s2_valid = 0; rr_ptr = 0; rsp_valid = 0; rsp_sum = 0; rsp_id = 0; rsp_carry = 0.
//       Operations in flight at reset are discarded and never reported.
//   - Stage S1 registers a_r, b_r, id_r, s1_valid. The adder is fed combinationally from a_r, b_r.
//   - Stage S2 registers rsp_sum, rsp_id, rsp_valid (= s2_valid).
//   - Advance logic:
//       adv2    = !s2_valid || rsp_ready
//       s1_free = !s1_valid || adv2
//   - Arbitration (combinational):
//       winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//       req_ready[winner] = s1_free; all other req_ready bits = 0.
//   - Accept: a handshake on edge k (req_valid[i] && req_ready[i]) loads S1 and sets
//     rr_ptr = (i+1) mod NUM_REQ. rr_ptr holds when nothing is accepted.
//   - S1 -> S2 on any edge where s1_valid && adv2.
//       s1_valid clears unless a new accept happens on the same edge.
//   - Latency: accept on edge k -> rsp_valid high after edge k+1 when not stalled.
//     Throughput is 1 result per cycle while rsp_ready = 1.
//   - Backpressure: rsp_valid=1 && rsp_ready=0 -> S2 holds rsp_sum, rsp_id, rsp_carry stable.
//     S1 holds if occupied, and all req_ready = 0. No result is dropped or duplicated.
//   - Simultaneous on one edge: S2 drains, S1 -> S2, and a new accept into S1 are all legal.
//   - Arithmetic: unsigned; overflow wraps mod 2^16 (0xFFFF + 1 = 0x0000).
//   - Requester rules: a requester must not drop req_valid or change operands until accepted.
//     req_valid must not depend on req_ready. req_ready may depend combinationally on req_valid.
//   - Fairness: a continuously requesting requester is granted within NUM_REQ accepts.
// CONFIGURATION
//   KS_ARB_CARRY_EN defined:
//     - Adds port rsp_carry and a carry bit in S2.
//     - rsp_carry = (sum_16 < a_r), registered alongside rsp_sum.
//   KS_ARB_CARRY_EN undefined:
//     - Port rsp_carry and its register do not exist; all other behaviour is identical.
// TESTING
//   1 Single op: req 0 offers a=2, b=5, rsp_ready=1
//       -> rsp_valid one cycle after the accept edge; rsp_sum=7, rsp_id=0.
//   2 Wrap: a=0xFFFF, b=1
//       -> rsp_sum=0x0000; with KS_ARB_CARRY_EN, rsp_carry=1.
//       a=14, b=1 -> rsp_sum=15; rsp_carry=0 (with KS_ARB_CARRY_EN).
//   3 Round robin: all 4 requesters valid continuously, rsp_ready=1
//       -> ids 0,1,2,3,0,... on consecutive cycles; rsp_sum matches each pair.
//   4 Backpressure: rsp_ready=0 for 5 cycles with 3 ops pending
//       -> rsp_sum/rsp_id stable; req_ready all 0 once S1 and S2 are full.
//       After release, results arrive in grant order with no loss.
//   5 Reset mid-flight: assert rst with S1 and S2 full
//       -> outputs 0 immediately; no stale result after release; first grant goes to requester 0.
//   6 Sparse: only req 2 valid (a=16, b=1), rr_ptr=3
//       -> req 2 granted the same cycle; rsp_sum=17, rsp_id=2.

Source files
------------

// File: rtl/ks_adder_arbiter.sv
// Round-robin shared 16-bit Kogge-Stone adder with a 2-stage operand/result pipeline.
// Define KS_ARB_CARRY_EN to add the registered rsp_carry_o output.
module ks_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [16*NUM_REQ-1:0] req_a_i,
    input  logic [16*NUM_REQ-1:0] req_b_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_valid_o,
    output logic [15:0]           rsp_sum_o,
    output logic [ID_W-1:0]       rsp_id_o
`ifdef KS_ARB_CARRY_EN
    ,
    output logic                  rsp_carry_o
`endif
);

    // Parallel-prefix add; bits below the current span keep their final generate,
    // so zero-filled propagate there is never consumed.
    function automatic logic [16:0] ks_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] g_n;
        logic [15:0] p_n;
        g = a & b;
        p = a ^ b;
        for (int l = 1; l < 16; l = l * 2) begin
            g_n = g | (p & (g << l));
            p_n = p & (p << l);
            g   = g_n;
            p   = p_n;
        end
        return {g[15], (a ^ b) ^ {g[14:0], 1'b0}};
    endfunction

    logic            s1_valid_q, s1_valid_d;
    logic [15:0]     a_q, a_d, b_q, b_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            adv2, s1_free, found, accept;
    logic [ID_W-1:0] winner;
    logic [15:0]     a_sel, b_sel, sum;
    logic [16:0]     ks_res;
    logic            unused_ks_carry;

    assign ks_res          = ks_add(a_q, b_q);
    assign sum             = ks_res[15:0];
    assign unused_ks_carry = ks_res[16];

    assign adv2    = !rsp_valid_q || rsp_ready_i;
    assign s1_free = !s1_valid_q || adv2;
    assign accept  = found && s1_free;

    // Two passes emulate a circular search starting at rr_ptr_q.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i] && (ID_W'(i) >= rr_ptr_q)) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        a_sel       = '0;
        b_sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                req_ready_o[i] = accept;
                a_sel          = req_a_i[16*i +: 16];
                b_sel          = req_b_i[16*i +: 16];
            end
        end
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        s1_valid_d  = s1_valid_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        if (accept) begin
            a_d        = a_sel;
            b_d        = b_sel;
            id_d       = winner;
            s1_valid_d = 1'b1;
            rr_ptr_d   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
        if (adv2) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_sum_d = sum;
                rsp_id_d  = id_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_id_o    = rsp_id_q;

`ifdef KS_ARB_CARRY_EN
    logic rsp_carry_q, rsp_carry_d;

    always_comb begin
        rsp_carry_d = rsp_carry_q;
        if (adv2 && s1_valid_q) begin
            rsp_carry_d = (sum < a_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_carry_q <= 1'b0;
        end else begin
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign rsp_carry_o = rsp_carry_q;
`endif

endmodule

// File: tb/tb_ks_adder_arbiter.sv
// Scoreboard bench for ks_adder_arbiter: per-requester operand queues, expected sums pushed on accept.
module tb_ks_adder_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [16*NUM_REQ-1:0] req_a = '0;
    logic [16*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_ready = 1'b1;
    logic                  rsp_valid;
    logic [15:0]           rsp_sum;
    logic [ID_W-1:0]       rsp_id;
`ifdef KS_ARB_CARRY_EN
    logic                  rsp_carry;
`endif

    ks_adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_a_i    (req_a),
        .req_b_i    (req_b),
        .req_ready_o(req_ready),
        .rsp_ready_i(rsp_ready),
        .rsp_valid_o(rsp_valid),
        .rsp_sum_o  (rsp_sum),
        .rsp_id_o   (rsp_id)
`ifdef KS_ARB_CARRY_EN
        ,
        .rsp_carry_o(rsp_carry)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     sum;
        logic            carry;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    logic [15:0] opa[NUM_REQ][64];
    logic [15:0] opb[NUM_REQ][64];
    int          head[NUM_REQ];
    int          tail[NUM_REQ];

    task automatic push_op(input int r, input logic [15:0] a, input logic [15:0] b);
        opa[r][tail[r] % 64] = a;
        opb[r][tail[r] % 64] = b;
        tail[r]++;
    endtask

    // Requester model: holds each operand pair until the monitor records its accept.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (head[i] != tail[i]) begin
                    req_valid[i]      = 1'b1;
                    req_a[16*i +: 16] = opa[i][head[i] % 64];
                    req_b[16*i +: 16] = opb[i][head[i] % 64];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_a[16*i +: 16] = '0;
                    req_b[16*i +: 16] = '0;
                end
            end
        end
    end

    // Monitor: pops on response handshakes, pushes on request handshakes.
    initial begin
        exp_t        e;
        logic [16:0] s;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                total++;
                if ($countones(req_ready) > 1) begin
                    bad++;
                    $display("FAIL ready_onehot: got %b, required at most one bit set", req_ready);
                end
                if (rsp_valid && rsp_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: got id=%0d sum=%h, required no response", rsp_id, rsp_sum);
                    end else begin
                        e = sb.pop_front();
                        if (rsp_id !== e.id || rsp_sum !== e.sum
`ifdef KS_ARB_CARRY_EN
                            || rsp_carry !== e.carry
`endif
                        ) begin
                            bad++;
                            $display("FAIL sb_result: got id=%0d sum=%h, required id=%0d sum=%h carry=%b",
                                     rsp_id, rsp_sum, e.id, e.sum, e.carry);
                        end
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        s = {1'b0, opa[i][head[i] % 64]} + {1'b0, opb[i][head[i] % 64]};
                        e.id    = ID_W'(i);
                        e.sum   = s[15:0];
                        e.carry = s[16];
                        sb.push_back(e);
                        head[i]++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        total++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_id !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b sum=%h id=%0d, required 0 0 0", rsp_valid, rsp_sum, rsp_id);
        end
`ifdef KS_ARB_CARRY_EN
        total++;
        if (rsp_carry !== 1'b0) begin
            bad++;
            $display("FAIL reset_carry: got %b, required 0", rsp_carry);
        end
`endif
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== '0) begin
            bad++;
            $display("FAIL reset_ready: got %b, required 0000", req_ready);
        end
    endtask

    task automatic test_single();
        bit seen = 1'b0;
        push_op(0, 16'd2, 16'd5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL single_accept: got no grant in 10 cycles, required grant to req 0");
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got rsp_valid=%b one cycle after accept edge, required 0", rsp_valid);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 16'd7 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL single_result: got v=%b sum=%0d id=%0d, required 1 7 0", rsp_valid, rsp_sum, rsp_id);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        push_op(0, 16'hFFFF, 16'h0001);
        push_op(0, 16'd14, 16'd1);
        wait_rsp(ok);
        total++;
        if (!ok || rsp_sum !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_sum: got ok=%b sum=%h, required 0000", ok, rsp_sum);
        end
`ifdef KS_ARB_CARRY_EN
        total++;
        if (rsp_carry !== 1'b1) begin
            bad++;
            $display("FAIL wrap_carry: got %b, required 1", rsp_carry);
        end
`endif
        wait_rsp(ok);
        total++;
        if (!ok || rsp_sum !== 16'd15) begin
            bad++;
            $display("FAIL nowrap_sum: got ok=%b sum=%0d, required 15", ok, rsp_sum);
        end
`ifdef KS_ARB_CARRY_EN
        total++;
        if (rsp_carry !== 1'b0) begin
            bad++;
            $display("FAIL nowrap_carry: got %b, required 0", rsp_carry);
        end
`endif
    endtask

    task automatic test_round_robin();
        bit          ok;
        logic [15:0] ea, eb;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                push_op(i, 16'(32'h4000 * i + 17 * k), 16'(32'hC000 + 5 * i + k));
            end
        end
        wait_rsp(ok);
        for (int n = 0; n < 12; n++) begin
            if (n > 0) @(negedge clk);
            ea = 16'(32'h4000 * (n % 4) + 17 * (n / 4));
            eb = 16'(32'hC000 + 5 * (n % 4) + (n / 4));
            total++;
            if (!ok || rsp_valid !== 1'b1 || rsp_id !== ID_W'(n % 4) || rsp_sum !== 16'(ea + eb)) begin
                bad++;
                $display("FAIL rr_seq[%0d]: got v=%b id=%0d sum=%h, required 1 %0d %h",
                         n, rsp_valid, rsp_id, rsp_sum, n % 4, 16'(ea + eb));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        push_op(1, 16'h1111, 16'h0001);
        push_op(2, 16'h2222, 16'h0002);
        push_op(3, 16'h3333, 16'h0003);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (!seen || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 16'h1112 || req_ready !== '0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h rdy=%b, required 1 1 1112 0000",
                         c, rsp_valid, rsp_id, rsp_sum, req_ready);
            end
        end
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_rsp(ok);
            total++;
            if (!ok || rsp_id !== ID_W'(k) || rsp_sum !== 16'(16'h1111 * k + k)) begin
                bad++;
                $display("FAIL bp_order[%0d]: got ok=%b id=%0d sum=%h, required id=%0d sum=%h",
                         k, ok, rsp_id, rsp_sum, k, 16'(16'h1111 * k + k));
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        bit seen = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        push_op(1, 16'h0A00, 16'h000A);
        push_op(2, 16'h0B00, 16'h000B);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) head[i] = tail[i];
        sb.delete();
        #1;
        total++;
        if (!seen || rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_id !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got seen=%b v=%b sum=%h id=%0d, required 1 0 0 0",
                     seen, rsp_valid, rsp_sum, rsp_id);
        end
        push_op(0, 16'h0100, 16'h0023);
        push_op(3, 16'h0300, 16'h0045);
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_first_grant: got %b, required 0001", req_ready);
        end
        wait_rsp(ok);
        total++;
        if (!ok || rsp_id !== 2'd0 || rsp_sum !== 16'h0123) begin
            bad++;
            $display("FAIL midrst_rsp0: got ok=%b id=%0d sum=%h, required id=0 sum=0123", ok, rsp_id, rsp_sum);
        end
        wait_rsp(ok);
        total++;
        if (!ok || rsp_id !== 2'd3 || rsp_sum !== 16'h0345) begin
            bad++;
            $display("FAIL midrst_rsp3: got ok=%b id=%0d sum=%h, required id=3 sum=0345", ok, rsp_id, rsp_sum);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_stale: got rsp_valid=%b id=%0d, required 0", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_sparse();
        bit ok;
        push_op(2, 16'd1, 16'd1);
        wait_rsp(ok);
        total++;
        if (!ok || rsp_id !== 2'd2 || rsp_sum !== 16'd2) begin
            bad++;
            $display("FAIL sparse_prime: got ok=%b id=%0d sum=%0d, required id=2 sum=2", ok, rsp_id, rsp_sum);
        end
        push_op(2, 16'd16, 16'd1);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL sparse_grant: got %b, required 0100", req_ready);
        end
        wait_rsp(ok);
        total++;
        if (!ok || rsp_id !== 2'd2 || rsp_sum !== 16'd17) begin
            bad++;
            $display("FAIL sparse_result: got ok=%b id=%0d sum=%0d, required id=2 sum=17", ok, rsp_id, rsp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_sparse();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
